// File: rtl/ysyx_25040111_pkg.sv
// Shared constants for the RV32E register-file scheduler: register addressing
// and writeback-unit encodings used by perf/debug logic.
package ysyx_25040111_pkg;
  localparam int REG_AW = 4;
  localparam int NREG   = 16;

  typedef enum logic {
    UNIT_ALU = 1'b0,
    UNIT_LSU = 1'b1
  } wb_unit_e;
endpackage

// File: rtl/ysyx_25040111_rr_arb2.sv
// Two-requester round-robin arbiter (ALU vs LSU) for the register-file write port.
// The history bit only moves on a genuine tie, so a lone requester never steals a turn.
module ysyx_25040111_rr_arb2
  import ysyx_25040111_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       req_alu,
  input  logic       req_lsu,
  output logic [1:0] gnt,
  output logic       grant_is_lsu
);
  logic last_lsu_q;
  logic last_lsu_d;
  logic lsu_win;

  always_comb begin
    // On a tie the unit that did not win the previous tie gets the port.
    lsu_win      = req_lsu & (~req_alu | ~last_lsu_q);
    gnt[UNIT_LSU] = reset & lsu_win;
    gnt[UNIT_ALU] = reset & req_alu & ~lsu_win;
    grant_is_lsu = lsu_win;
    last_lsu_d   = (req_alu & req_lsu) ? lsu_win : last_lsu_q;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      last_lsu_q <= 1'b0;
    end else begin
      last_lsu_q <= last_lsu_d;
    end
  end
endmodule

// File: rtl/ysyx_25040111_rf_sched.sv
// Register-file scheduler: owns the single write port (ALU/LSU round-robin) and a
// per-register busy scoreboard that stalls issue on RAW/WAW hazards.
module ysyx_25040111_rf_sched
  import ysyx_25040111_pkg::*;
#(
  parameter int NREG = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [1:0]        issue_ren,
  input  logic [REG_AW-1:0] issue_rs1,
  input  logic [REG_AW-1:0] issue_rs2,
  input  logic              issue_rd_wen,
  input  logic [REG_AW-1:0] issue_rd,
  input  logic              alu_wb_valid,
  input  logic              lsu_wb_valid,
  output logic              alu_wb_ready,
  output logic              lsu_wb_ready,
  input  logic [REG_AW-1:0] alu_wb_addr,
  input  logic [REG_AW-1:0] lsu_wb_addr,
  input  logic [31:0]       alu_wb_data,
  input  logic [31:0]       lsu_wb_data,
  output logic              rf_wen,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [31:0]       rf_wdata,
  output logic [NREG-1:0]   busy
);
  logic [1:0]      gnt;
  logic            grant_is_lsu;
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic [NREG-1:0] busy_eff;
  logic [NREG-1:0] clr;
  logic [NREG-1:0] set;
  logic            set_en;

  ysyx_25040111_rr_arb2 u_arb (
    .clock        (clock),
    .reset        (reset),
    .req_alu      (alu_wb_valid),
    .req_lsu      (lsu_wb_valid),
    .gnt          (gnt),
    .grant_is_lsu (grant_is_lsu)
  );

  always_comb begin
    alu_wb_ready = gnt[UNIT_ALU];
    lsu_wb_ready = gnt[UNIT_LSU];
    rf_waddr     = grant_is_lsu ? lsu_wb_addr : alu_wb_addr;
    rf_wdata     = grant_is_lsu ? lsu_wb_data : alu_wb_data;
    // x0 writes are still handshaked so the unit drains, but never reach the RF.
    rf_wen       = (|gnt) & (rf_waddr != '0);
  end

  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_onehot
      assign clr[gi] = rf_wen & (rf_waddr == REG_AW'(gi));
      assign set[gi] = set_en & (issue_rd == REG_AW'(gi));
    end
  endgenerate

  always_comb begin
    // Same-cycle completions are forwarded by the RF, so check against busy_eff.
    busy_eff    = busy_q & ~clr;
    issue_ready = reset
                & ~(issue_ren[0] & busy_eff[issue_rs1])
                & ~(issue_ren[1] & busy_eff[issue_rs2])
                & ~(issue_rd_wen & busy_eff[issue_rd]);
    set_en      = issue_valid & issue_ready & issue_rd_wen & (issue_rd != '0);
    busy_d      = busy_eff | set;
    busy_d[0]   = 1'b0;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy = busy_q;
endmodule
